b14_trace_capture: RTL and testbench
====================================

# b14_trace_capture

Downstream monitor for the b14 concolic harness. Samples the DUT bus outputs (`addr`, `datao`, `rd`, `wr`) every cycle and records each bus access as a timestamped event in an internal FIFO. Capture is armed by the controller and triggered by the `__obs` observation bit. The FIFO is drained through a valid/ready port into the trace writer. It replaces ad-hoc `$strobe` output with a synthesizable, cycle-exact response record.

## Interface
- `ADDR_W`, default 20: DUT address width.
- `DATA_W`, default 31: DUT data width.
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `TS_W`, default 16: timestamp width.
- `POST`, default 8: events recorded per capture before automatic stop; 0 means unlimited.

Ports:
- `clock` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `arm` input 1: pulse; starts a new capture and clears `overflow` and `dropped`.
- `stop` input 1: pulse; ends capture.
- `obs` input 1: trigger, driven from the harness `__obs` bit.
- `addr` input ADDR_W: DUT address.
- `datao` input DATA_W: DUT write data.
- `rd` input 1: DUT read strobe.
- `wr` input 1: DUT write strobe.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts the head.
- `out_kind` output 2: 01 read, 10 write, 11 read and write.
- `out_addr` output ADDR_W: recorded address.
- `out_data` output DATA_W: recorded `datao`.
- `out_ts` output TS_W: cycle stamp of the event.
- `state` output 2: 0 IDLE, 1 ARMED, 2 RUN, 3 DONE.
- `count` output log2(DEPTH)+1: FIFO occupancy.
- `overflow` output 1: sticky; set when an event is lost.
- `dropped` output 16: lost-event counter; saturates at 0xFFFF.

## Operation
- **Timestamp counter**
  - Free-running, TS_W bits.
  - 0 in the cycle after reset; +1 every cycle; wraps from all-ones to 0.
- **Event definition**
  - An event occurs in a cycle where `state`==RUN and (`rd`|`wr`).
  - Recorded fields: kind={`wr`,`rd`}, `addr`, `datao`, current timestamp.
  - Every qualifying cycle is a separate event; there is no merging.
- **State machine**
  - IDLE -> ARMED on `arm`.
  - ARMED -> RUN on the first cycle with `obs`=1.
    - That same cycle is sampled as RUN, so an access in the trigger cycle is recorded.
  - RUN -> DONE when `stop` is asserted (that cycle's access is still recorded), or when the POST-th event is pushed (POST≠0).
  - DONE -> ARMED on `arm`.
  - `arm` in any state forces ARMED, clears the event tally, `overflow` and `dropped`. FIFO contents are kept.
  - `arm` and `stop` in the same cycle: `arm` wins.
- **FIFO**
  - First-word fall-through.
  - Pop occurs when `out_valid`&`out_ready`.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - A rejected push sets `overflow`, increments `dropped`, and does not count toward POST.
  - Simultaneous push and pop leaves `count` unchanged.
- **Output stability**
  - `out_*` are stable while `out_valid`=1 and `out_ready`=0.
  - When `out_valid`=0, `out_*` are don't-care.
- **Reset values**
  - `state`=IDLE, `out_valid`=0, `count`=0, `overflow`=0, `dropped`=0, timestamp=0.
  - `out_kind`/`out_addr`/`out_data`/`out_ts` are 0.
  - Reset mid-capture discards the FIFO contents.

## Timing
- An event sampled at edge N is visible on `out_*` with `out_valid`=1 after edge N, when the FIFO was empty.
- A pop at edge N presents the next entry after edge N, giving one entry per cycle when `out_ready` is held high.
- `state` updates at the edge following the causing input (`arm`, `obs`, `stop`, or the final push).
- `count`, `overflow` and `dropped` are registered and update at the same edge as the push or pop that changes them.

## Structure
- Package `b14_trace_pkg` holds:
  - the state enum (IDLE/ARMED/RUN/DONE);
  - the kind encodings;
  - the event record typedef {kind, addr, data, ts}.
- The FIFO is one sub-module, `trace_fifo`, parameterised by width and DEPTH. It contains:
  - the storage array and read/write pointers (one extra wrap bit);
  - `count`, full and empty.
- The top level holds the FSM, the timestamp counter, the POST tally and the overflow logic.

## Test plan
- **Basic read capture.** Reset, `arm`, `obs`=1 at cycle 3 with `rd`=1, `addr`=0x00010. Expect one entry: kind=01, addr=0x00010, ts=3; `out_valid` high at cycle 4.
- **Trigger gating.** With `arm` set, drive `wr`=1 for cycles 1–4 and `obs`=1 only from cycle 5. Expect no entries until cycle 5, then kind=10 with `datao` recorded.
- **POST stop.** POST=8, continuous `rd`=1 after trigger. Expect exactly 8 entries with consecutive ts and `state`=DONE; later accesses are ignored.
- **Overflow.** DEPTH=16, POST=0, `out_ready`=0, 20 events. Expect `count`=16, `overflow`=1, `dropped`=4; the first 16 events are retained in order.
- **Full with simultaneous pop.** FIFO full, `out_ready`=1 and a push in the same cycle. Expect `count` stays 16, `dropped` unchanged, new entry at the tail.
- **Re-arm and wrap.** With TS_W=4, capture across ts 15→0. Expect ts values 14, 15, 0, 1. Then `arm` and `stop` in the same cycle: expect `state`=ARMED, `overflow` cleared.

Source files
------------

// File: rtl/b14_trace_pkg.sv
// Shared types for the b14 trace capture monitor: FSM states, access kinds
// and the event record layout.
package b14_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Kind is simply {wr, rd}; KIND_NONE never reaches the FIFO.
  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_RD   = 2'b01,
    KIND_WR   = 2'b10,
    KIND_RW   = 2'b11
  } kind_e;

  // Record geometry as seen by the trace writer in the default harness build.
  localparam int REC_ADDR_W = 20;
  localparam int REC_DATA_W = 31;
  localparam int REC_TS_W   = 16;

  // Field order {kind, addr, data, ts}; the top level packs its FIFO words in
  // the same order at its own parameterised widths.
  typedef struct packed {
    kind_e                  kind;
    logic [REC_ADDR_W-1:0]  addr;
    logic [REC_DATA_W-1:0]  data;
    logic [REC_TS_W-1:0]    ts;
  } trace_event_t;

  function automatic kind_e access_kind(input logic wr, input logic rd);
    return kind_e'({wr, rd});
  endfunction

endpackage

// File: rtl/b14_trace_capture_fifo.sv
// First-word fall-through FIFO for trace events. Pointers carry one extra
// wrap bit; a push is accepted when full only if a pop frees a slot the
// same cycle, in which case the new word lands in the slot just vacated.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     push_ok_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic             full, pop_ok, push_ok;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full || pop_ok);
  assign push_ok_o = push_ok;
  assign count_o   = count_q;
  assign head_o    = mem[rd_ptr_q[AW-1:0]];

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/b14_trace_capture.sv
// Bus trace monitor for the b14 harness: timestamps every DUT bus access
// while a capture is running and queues it for the trace writer.
module b14_trace_capture
  import b14_trace_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 31,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int POST   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     obs,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        datao,
  input  logic                     rd,
  input  logic                     wr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped
);

  localparam int TALLY_W = (POST < 2) ? 1 : $clog2(POST + 1);

  typedef struct packed {
    kind_e              kind;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [TS_W-1:0]    ts;
  } event_t;

  localparam int EV_W = $bits(event_t);

  state_e              state_q;
  logic [TS_W-1:0]     ts_q;
  logic [TALLY_W-1:0]  tally_q;
  logic                overflow_q;
  logic [15:0]         dropped_q;

  event_t              push_ev, head_ev;
  logic [EV_W-1:0]     head_flat;
  logic                sampled_run, push_req, push_ok, fifo_empty, pop, final_push;

  // The trigger cycle itself counts as RUN so its access is captured.
  // An arm cycle restarts the capture and records nothing.
  assign sampled_run = (state_q == ST_RUN) || ((state_q == ST_ARMED) && obs);
  assign push_req    = !arm && sampled_run && (rd || wr);
  assign final_push  = push_ok && (POST != 0) && (tally_q == TALLY_W'(POST - 1));
  assign pop         = out_valid && out_ready;

  assign push_ev = '{kind: access_kind(wr, rd), addr: addr, data: datao, ts: ts_q};

  trace_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clock),
    .srst        (reset),
    .push_i      (push_req),
    .push_data_i (push_ev),
    .pop_i       (pop),
    .head_o      (head_flat),
    .empty_o     (fifo_empty),
    .push_ok_o   (push_ok),
    .count_o     (count)
  );

  assign head_ev   = event_t'(head_flat);
  assign out_valid = !fifo_empty;
  // Head fields are forced to zero when nothing is queued so the port
  // reads all-zero out of reset rather than stale RAM.
  assign out_kind  = out_valid ? head_ev.kind : KIND_NONE;
  assign out_addr  = out_valid ? head_ev.addr : '0;
  assign out_data  = out_valid ? head_ev.data : '0;
  assign out_ts    = out_valid ? head_ev.ts   : '0;

  assign state    = state_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;

  // Capture FSM, timestamp, post-trigger tally and loss accounting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      tally_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (arm) begin
        state_q    <= ST_ARMED;
        tally_q    <= '0;
        overflow_q <= 1'b0;
        dropped_q  <= '0;
      end else begin
        if (push_ok && (POST != 0)) tally_q <= tally_q + 1'b1;
        if (push_req && !push_ok) begin
          overflow_q <= 1'b1;
          if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 1'b1;
        end
        case (state_q)
          ST_ARMED: if (obs) state_q <= (stop || final_push) ? ST_DONE : ST_RUN;
          ST_RUN:   if (stop || final_push) state_q <= ST_DONE;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_b14_trace_capture.sv
// Scoreboard bench for b14_trace_capture. Two instances share the bus
// stimulus: dut_a stops after 8 events, dut_b captures without limit.
// Timestamps are 4 bits wide so wrap-around is reachable quickly.
module tb_b14_trace_capture;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 31;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 4;

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0, stop = 1'b0, obs = 1'b0, rd = 1'b0, wr = 1'b0, ready = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] datao = '0;

  logic a_valid, b_valid, a_ovf, b_ovf;
  logic [1:0] a_kind, b_kind, a_state, b_state;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic [TS_W-1:0] a_ts, b_ts;
  logic [4:0] a_count, b_count;
  logic [15:0] a_drop, b_drop;

  logic sel_b = 1'b1;
  logic m_valid, m_ovf;
  logic [1:0] m_kind, m_state;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [TS_W-1:0] m_ts;
  logic [4:0] m_count;
  logic [15:0] m_drop;

  assign m_valid = sel_b ? b_valid : a_valid;
  assign m_ovf   = sel_b ? b_ovf   : a_ovf;
  assign m_kind  = sel_b ? b_kind  : a_kind;
  assign m_state = sel_b ? b_state : a_state;
  assign m_addr  = sel_b ? b_addr  : a_addr;
  assign m_data  = sel_b ? b_data  : a_data;
  assign m_ts    = sel_b ? b_ts    : a_ts;
  assign m_count = sel_b ? b_count : a_count;
  assign m_drop  = sel_b ? b_drop  : a_drop;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic [TS_W-1:0] model_ts = '0;

  always #5 clock = ~clock;

  // Reference timestamp: value the DUT stamps on an access sampled at the next edge.
  always @(posedge clock) model_ts <= reset ? '0 : model_ts + 1'b1;

  b14_trace_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .POST(8)) dut_a (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .obs(obs), .addr(addr), .datao(datao),
    .rd(rd), .wr(wr), .out_valid(a_valid), .out_ready(ready), .out_kind(a_kind), .out_addr(a_addr),
    .out_data(a_data), .out_ts(a_ts), .state(a_state), .count(a_count), .overflow(a_ovf), .dropped(a_drop));

  b14_trace_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .POST(0)) dut_b (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .obs(obs), .addr(addr), .datao(datao),
    .rd(rd), .wr(wr), .out_valid(b_valid), .out_ready(ready), .out_kind(b_kind), .out_addr(b_addr),
    .out_data(b_data), .out_ts(b_ts), .state(b_state), .count(b_count), .overflow(b_ovf), .dropped(b_drop));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    {arm, stop, obs, rd, wr, ready} = '0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic expect_push(input logic [1:0] kind, input logic [TS_W-1:0] ts);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = datao; e.ts = ts;
    q.push_back(e);
  endtask

  // Pops everything queued with ready held high; one entry per cycle expected.
  task automatic drain_check(input string name);
    int n, cyc;
    exp_t e;
    {obs, rd, wr} = '0;
    ready = 1'b1;
    n = q.size();
    cyc = 0;
    while (q.size() > 0 && cyc < n + 40) begin
      if (m_valid) begin
        e = q.pop_front();
        checks++;
        if (m_kind !== e.kind || m_addr !== e.addr || m_data !== e.data || m_ts !== e.ts) begin
          errors++;
          $display("FAIL %s entry: got kind=%b addr=%h data=%h ts=%0d, want kind=%b addr=%h data=%h ts=%0d",
                   name, m_kind, m_addr, m_data, m_ts, e.kind, e.addr, e.data, e.ts);
        end else
          $display("%s pop: kind=%b addr=%h data=%h ts=%0d", name, m_kind, m_addr, m_data, m_ts);
      end
      cyc++;
      tick();
    end
    ready = 1'b0;
    checks++;
    if (q.size() != 0 || cyc != n) begin
      errors++;
      $display("FAIL %s drain: took %0d cycles with %0d left, want %0d cycles", name, cyc, q.size(), n);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s empty: out_valid=%b want 0", name, m_valid);
    end
  endtask

  task automatic test_reset();
    sel_b = 1'b1;
    do_reset();
    checks++;
    if (m_state !== 2'd0 || m_valid !== 1'b0 || m_count !== 5'd0) begin
      errors++;
      $display("FAIL reset ctl: state=%0d valid=%b count=%0d want 0/0/0", m_state, m_valid, m_count);
    end
    checks++;
    if (m_ovf !== 1'b0 || m_drop !== 16'd0) begin
      errors++;
      $display("FAIL reset loss: overflow=%b dropped=%0d want 0/0", m_ovf, m_drop);
    end
    checks++;
    if (m_kind !== 2'b00 || m_addr !== '0 || m_data !== '0 || m_ts !== '0) begin
      errors++;
      $display("FAIL reset out: kind=%b addr=%h data=%h ts=%0d want zeros", m_kind, m_addr, m_data, m_ts);
    end
    $display("reset: state=%0d valid=%b count=%0d", m_state, m_valid, m_count);
  endtask

  task automatic test_basic_read();
    sel_b = 1'b1;
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    obs = 1'b1; rd = 1'b1; addr = 20'h00010; datao = 31'h0000_1234;
    expect_push(2'b01, 4'd3);
    tick();
    obs = 1'b0; rd = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_count !== 5'd1 || m_state !== 2'd2) begin
      errors++;
      $display("FAIL basic trig: valid=%b count=%0d state=%0d want 1/1/2", m_valid, m_count, m_state);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (m_state !== 2'd3) begin
      errors++;
      $display("FAIL basic stop: state=%0d want 3", m_state);
    end
    drain_check("basic");
  endtask

  task automatic test_trigger_gating();
    sel_b = 1'b1;
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; addr = 20'h00A00 + 20'(i); datao = 31'h5000_0000 + 31'(i);
      tick();
      checks++;
      if (m_count !== 5'd0 || m_state !== 2'd1) begin
        errors++;
        $display("FAIL gating pre%0d: count=%0d state=%0d want 0/1", i, m_count, m_state);
      end
    end
    obs = 1'b1; wr = 1'b1; addr = 20'h00A55; datao = 31'h7ABC_DEF0;
    expect_push(2'b10, model_ts);
    tick();
    obs = 1'b0; wr = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    checks++;
    if (m_count !== 5'd1) begin
      errors++;
      $display("FAIL gating count: count=%0d want 1", m_count);
    end
    drain_check("gating");
  endtask

  task automatic test_post_stop();
    sel_b = 1'b0;
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs = 1'b1; rd = 1'b1; addr = 20'h00100 + 20'(i); datao = 31'(i * 3);
      if (i < 8) expect_push(2'b01, model_ts);
      tick();
    end
    obs = 1'b0; rd = 1'b0;
    checks++;
    if (m_state !== 2'd3 || m_count !== 5'd8 || m_drop !== 16'd0) begin
      errors++;
      $display("FAIL post: state=%0d count=%0d dropped=%0d want 3/8/0", m_state, m_count, m_drop);
    end
    drain_check("post");
    sel_b = 1'b1;
  endtask

  task automatic test_overflow();
    sel_b = 1'b1;
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      obs = 1'b1; rd = 1'b1; addr = 20'h00200 + 20'(i); datao = 31'h0100_0000 + 31'(i);
      if (i < 16) expect_push(2'b01, model_ts);
      tick();
    end
    obs = 1'b0; rd = 1'b0;
    checks++;
    if (m_count !== 5'd16 || m_ovf !== 1'b1 || m_drop !== 16'd4 || m_state !== 2'd2) begin
      errors++;
      $display("FAIL overflow: count=%0d ovf=%b dropped=%0d state=%0d want 16/1/4/2",
               m_count, m_ovf, m_drop, m_state);
    end
    $display("overflow: count=%0d ovf=%b dropped=%0d", m_count, m_ovf, m_drop);
  endtask

  // Continues from a full FIFO left by test_overflow.
  task automatic test_full_pop();
    exp_t e;
    e = q.pop_front();
    checks++;
    if (m_valid !== 1'b1 || m_addr !== e.addr || m_ts !== e.ts) begin
      errors++;
      $display("FAIL fullpop head: valid=%b addr=%h ts=%0d want 1/%h/%0d", m_valid, m_addr, m_ts, e.addr, e.ts);
    end
    ready = 1'b1; rd = 1'b1; addr = 20'h00FFF; datao = 31'h2222_3333;
    expect_push(2'b01, model_ts);
    tick();
    ready = 1'b0; rd = 1'b0;
    checks++;
    if (m_count !== 5'd16 || m_drop !== 16'd4) begin
      errors++;
      $display("FAIL fullpop: count=%0d dropped=%0d want 16/4", m_count, m_drop);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    drain_check("fullpop");
  endtask

  task automatic test_rearm_wrap();
    sel_b = 1'b1;
    do_reset();
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 40 && model_ts != 4'd14; k++) tick();
    for (int i = 0; i < 4; i++) begin
      obs = 1'b1; rd = 1'b1; addr = 20'h00300 + 20'(i); datao = 31'(i);
      expect_push(2'b01, 4'((14 + i) % 16));
      tick();
    end
    drain_check("wrap");
    for (int i = 0; i < 18; i++) begin
      rd = 1'b1; addr = 20'h00400 + 20'(i); datao = 31'(100 + i);
      if (i < 16) expect_push(2'b01, model_ts);
      tick();
    end
    rd = 1'b0;
    checks++;
    if (m_ovf !== 1'b1 || m_drop !== 16'd2) begin
      errors++;
      $display("FAIL rearm pre: ovf=%b dropped=%0d want 1/2", m_ovf, m_drop);
    end
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    checks++;
    if (m_state !== 2'd1 || m_ovf !== 1'b0 || m_drop !== 16'd0 || m_count !== 5'd16) begin
      errors++;
      $display("FAIL rearm: state=%0d ovf=%b dropped=%0d count=%0d want 1/0/0/16",
               m_state, m_ovf, m_drop, m_count);
    end
    drain_check("rearm");
  endtask

  initial begin
    tick();
    test_reset();
    test_basic_read();
    test_trigger_gating();
    test_post_stop();
    test_overflow();
    test_full_pop();
    test_rearm_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
